// File: rtl/count_checker.sv
// Sequence checker for an upstream wrap/step-back counter: syncs, locks and counts mismatches.
// Optional `COUNT_CHECK_INV_EN also flags samples whose count_inv is not the bitwise inverse of count.
module count_checker #(
    parameter int W         = 8,
    parameter int WRAP_AT   = 10,
    parameter int STEP_BACK = 8,
    parameter int LOCK_N    = 4,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [W-1:0]     count,
    input  logic [W-1:0]     count_inv,
    input  logic             clear,
    output logic [1:0]       state,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0]       ST_IDLE   = 2'd0;
    localparam logic [1:0]       ST_SYNC   = 2'd1;
    localparam logic [1:0]       ST_LOCKED = 2'd2;
    localparam logic [W-1:0]     WRAP_V    = W'(WRAP_AT);
    localparam logic [W-1:0]     STEP_V    = W'(STEP_BACK);
    localparam logic [W-1:0]     ONE_V     = W'(1);
    localparam logic [3:0]       LOCK_V    = 4'(LOCK_N);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_ZERO  = {ERR_W{1'b0}};

    // Next value the upstream counter should produce after p (wraps modulo 2^W).
    function automatic logic [W-1:0] predict(input logic [W-1:0] p);
        if (p >= WRAP_V) begin
            return p - STEP_V;
        end else begin
            return p + ONE_V;
        end
    endfunction

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     prev_q, prev_d;
    logic [3:0]       good_q, good_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             match_s;
    logic             err_s;

`ifdef COUNT_CHECK_INV_EN
    assign match_s = (count == predict(prev_q)) && (count_inv == ~count);
`else
    logic unused_inv_s;
    assign unused_inv_s = ^count_inv;
    assign match_s      = (count == predict(prev_q));
`endif

    // Sync/lock FSM and prediction register; en=0 cycles hold everything.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        good_d  = good_q;
        err_s   = 1'b0;
        if (en) begin
            prev_d = count;
            case (state_q)
                ST_IDLE: begin
                    good_d  = 4'd0;
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (match_s) begin
                        good_d = good_q + 4'd1;
                        if (good_d == LOCK_V) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_SYNC;
                        end
                    end else begin
                        good_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (match_s) begin
                        state_d = ST_LOCKED;
                    end else begin
                        err_s   = 1'b1;
                        good_d  = 4'd0;
                        state_d = ST_SYNC;
                    end
                end
                default: begin
                    good_d  = 4'd0;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Error bookkeeping; a same-edge error survives clear as a single count.
    always_comb begin
        err_pulse_d = err_s;
        locked_d    = (state_d == ST_LOCKED);
        if (clear) begin
            err_count_d  = err_s ? ERR_ONE : ERR_ZERO;
            err_sticky_d = err_s;
        end else if (err_s && (err_count_q != ERR_MAX)) begin
            err_count_d  = err_count_q + ERR_ONE;
            err_sticky_d = 1'b1;
        end else begin
            err_count_d  = err_count_q;
            err_sticky_d = err_sticky_q | err_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prev_q       <= {W{1'b0}};
            good_q       <= 4'd0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= ERR_ZERO;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign state      = state_q;
    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: reference model pushes expectations, monitor pops and compares.
module tb_count_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] count = 8'd0;
    logic [7:0] count_inv = 8'hFF;
    logic       clear = 1'b0;
    logic [1:0] state;
    logic       locked, err_pulse, err_sticky;
    logic [7:0] err_count;

    count_checker dut (
        .clk(clk), .rst_n(rst_n), .en(en), .count(count), .count_inv(count_inv),
        .clear(clear), .state(state), .locked(locked), .err_pulse(err_pulse),
        .err_sticky(err_sticky), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int lk; int pl; int sk; int ec;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;

    // reference model state (plain integers)
    int m_mode = 0;      // 0 idle, 1 hunting, 2 locked
    int m_prev = 0;
    int m_run = 0;
    int m_sticky = 0;
    int m_cnt = 0;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int next_of(input int p);
        if (p >= 10) return (p - 8 + 256) % 256;
        return (p + 1) % 256;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_run = 0; m_sticky = 0; m_cnt = 0;
    endtask

    // Drive one sample at the falling edge and push what the next rising edge must produce.
    task automatic cycle(input bit e, input int c, input int ci, input bit clr);
        exp_t x;
        int   err;
        bit   good;
        @(negedge clk);
        en = e; count = 8'(c); count_inv = 8'(ci); clear = clr;
        good = (c == next_of(m_prev));
`ifdef COUNT_CHECK_INV_EN
        good = good && (ci == (255 - c));
`endif
        err = 0;
        if (e) begin
            if (m_mode == 0) begin
                m_run = 0; m_mode = 1;
            end else if (m_mode == 1) begin
                if (good) begin
                    m_run++;
                    if (m_run == 4) m_mode = 2;
                end else m_run = 0;
            end else if (!good) begin
                err = 1; m_run = 0; m_mode = 1;
            end
            m_prev = c;
        end
        if (clr) begin
            m_cnt = err; m_sticky = err;
        end else begin
            m_cnt = (m_cnt + err > 255) ? 255 : m_cnt + err;
            m_sticky = m_sticky | err;
        end
        x.st = m_mode; x.lk = (m_mode == 2); x.pl = err; x.sk = m_sticky; x.ec = m_cnt;
        sb.push_back(x);
    endtask

    task automatic good_sample(input bit clr);
        int c;
        c = next_of(m_prev);
        cycle(1'b1, c, 255 - c, clr);
    endtask

    // Monitor: one expectation per rising edge, sampled just after it.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("state", int'(state), x.st);
            chk("locked", int'(locked), x.lk);
            chk("err_pulse", int'(err_pulse), x.pl);
            chk("err_sticky", int'(err_sticky), x.sk);
            chk("err_count", int'(err_count), x.ec);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_pulse"}, int'(err_pulse), 0);
        chk({tag, "_sticky"}, int'(err_sticky), 0);
        chk({tag, "_count"}, int'(err_count), 0);
    endtask

    initial begin
        int c, ci;
        repeat (3) @(posedge clk);
        #2 chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // lock on 0..4, then run through the step-back at 10
        for (int i = 0; i <= 4; i++) cycle(1'b1, i, 255 - i, 1'b0);
        for (int i = 5; i <= 10; i++) cycle(1'b1, i, 255 - i, 1'b0);
        cycle(1'b1, 2, 253, 1'b0);
        cycle(1'b1, 3, 252, 1'b0);
        cycle(1'b1, 5, 250, 1'b0);         // expected 4: error out of lock
        cycle(1'b0, 77, 0, 1'b0);          // idle cycle holds everything
        for (int i = 0; i < 4; i++) good_sample(1'b0);
        cycle(1'b1, 200, 55, 1'b1);        // mismatch and clear on the same edge
        good_sample(1'b1);                 // clear alone
        for (int i = 0; i < 4; i++) good_sample(1'b0);
        c = next_of(m_prev);
        cycle(1'b1, c, 255, 1'b0);         // correct count, bad inverse
        cycle(1'b0, 0, 0, 1'b0);
        good_sample(1'b0);

        // random traffic with occasional clears, then without clears to reach saturation
        for (int i = 0; i < 7500; i++) begin
            c = ($urandom_range(0, 99) < 12) ? int'($urandom_range(0, 255)) : next_of(m_prev);
            ci = ($urandom_range(0, 99) < 3) ? int'($urandom_range(0, 255)) : 255 - c;
            cycle($urandom_range(0, 9) != 0, c, ci, (i < 1500) && ($urandom_range(0, 99) == 0));
        end

        // asynchronous reset while locked
        for (int i = 0; i < 5; i++) good_sample(1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i <= 4; i++) cycle(1'b1, i, 255 - i, 1'b0);
        @(posedge clk);
        #3;
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
